// File: rtl/axi_read_arbiter.sv
// Two-master to one-slave AXI4 read arbiter: master 0 (video) wins by fixed priority,
// one burst outstanding. Optional starvation guard for master 1 under `STARVE_GUARD_EN.
module axi_read_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int LEN_W     = 8,
    parameter int MAX_DEFER = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_ar_valid,
    output logic              m0_ar_ready,
    input  logic [ADDR_W-1:0] m0_ar_addr,
    input  logic [LEN_W-1:0]  m0_ar_len,
    input  logic [1:0]        m0_ar_burst,
    output logic              m0_r_valid,
    input  logic              m0_r_ready,
    output logic [DATA_W-1:0] m0_r_data,
    output logic              m0_r_last,
    input  logic              m1_ar_valid,
    output logic              m1_ar_ready,
    input  logic [ADDR_W-1:0] m1_ar_addr,
    input  logic [LEN_W-1:0]  m1_ar_len,
    input  logic [1:0]        m1_ar_burst,
    output logic              m1_r_valid,
    input  logic              m1_r_ready,
    output logic [DATA_W-1:0] m1_r_data,
    output logic              m1_r_last,
    output logic              s_ar_valid,
    input  logic              s_ar_ready,
    output logic [ADDR_W-1:0] s_ar_addr,
    output logic [LEN_W-1:0]  s_ar_len,
    output logic [1:0]        s_ar_burst,
    input  logic              s_r_valid,
    output logic              s_r_ready,
    input  logic [DATA_W-1:0] s_r_data,
    input  logic              s_r_last,
    output logic              grant_id
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t            state_q, state_d;
    logic              grant_q, grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [1:0]        burst_q, burst_d;
    logic              pick1;
    logic              starve;
    logic              beat_rdy;

`ifdef STARVE_GUARD_EN
    logic [3:0] defer_q, defer_d;

    assign starve = (defer_q == 4'(MAX_DEFER)) && m1_ar_valid;

    // Counts master-0 wins taken while master 1 was waiting; saturates at the limit.
    always_comb begin
        defer_d = defer_q;
        if (state_q == IDLE && (m0_ar_valid || m1_ar_valid)) begin
            if (pick1) begin
                defer_d = 4'd0;
            end else if (m1_ar_valid && defer_q != 4'(MAX_DEFER)) begin
                defer_d = defer_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            defer_q <= 4'd0;
        end else begin
            defer_q <= defer_d;
        end
    end
`else
    // MAX_DEFER only matters when the starvation guard is built in.
    logic unused_max_defer;
    assign unused_max_defer = ^4'(MAX_DEFER);
    assign starve           = 1'b0;
`endif

    assign pick1 = m1_ar_valid && (!m0_ar_valid || starve);

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        addr_d      = addr_q;
        len_d       = len_q;
        burst_d     = burst_q;
        m0_ar_ready = 1'b0;
        m1_ar_ready = 1'b0;
        s_ar_valid  = 1'b0;
        beat_rdy    = 1'b0;
        m0_r_valid  = 1'b0;
        m1_r_valid  = 1'b0;
        m0_r_last   = 1'b0;
        m1_r_last   = 1'b0;
        case (state_q)
            IDLE: begin
                if (m0_ar_valid || m1_ar_valid) begin
                    m0_ar_ready = !pick1;
                    m1_ar_ready = pick1;
                    grant_d     = pick1;
                    addr_d      = pick1 ? m1_ar_addr  : m0_ar_addr;
                    len_d       = pick1 ? m1_ar_len   : m0_ar_len;
                    burst_d     = pick1 ? m1_ar_burst : m0_ar_burst;
                    state_d     = ADDR;
                end
            end
            ADDR: begin
                s_ar_valid = 1'b1;
                if (s_ar_ready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                // Completion depends only on s_r_last, so any burst length routes correctly.
                beat_rdy   = grant_q ? m1_r_ready : m0_r_ready;
                m0_r_valid = !grant_q && s_r_valid;
                m1_r_valid = grant_q && s_r_valid;
                m0_r_last  = !grant_q && s_r_last;
                m1_r_last  = grant_q && s_r_last;
                if (s_r_valid && beat_rdy && s_r_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            burst_q <= burst_d;
        end
    end

    assign s_r_ready  = beat_rdy;
    assign s_ar_addr  = addr_q;
    assign s_ar_len   = len_q;
    assign s_ar_burst = burst_q;
    assign grant_id   = grant_q;
    assign m0_r_data  = s_r_data;
    assign m1_r_data  = s_r_data;

endmodule
